bcd_updown_counter_7seg: RTL and testbench

Parametrised multi-digit synchronous BCD up/down counter with an integrated per-digit 7-segment decoder. It is the next generation of the single-digit counter-plus-decoder pair. It adds digit count, count direction, count enable, parallel load with validation, terminal-count output and leading-zero blanking. It drives the board HEX displays directly from the top level.

---
 rtl/bcd_updown_counter_7seg_if.sv | 24 ++
 rtl/bcd_updown_counter_7seg.sv | 163 ++++++++++++++++
 tb/tb_bcd_updown_counter_7seg.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_updown_counter_7seg_if.sv
// Counter control and display bus: the controller drives the count controls,
// and the counter returns the count, the status flags and the segment drive.
interface bcd_updown_counter_7seg_if #(
    parameter int unsigned DIGITS = 2
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   bcd;
    logic                  tc;
    logic                  load_err;
    logic [7*DIGITS-1:0]   segments;

    modport master (
        output en, up, load, load_val,
        input  bcd, tc, load_err, segments
    );

    modport slave (
        input  en, up, load, load_val,
        output bcd, tc, load_err, segments
    );
endinterface

// File: rtl/bcd_updown_counter_7seg.sv
// Multi-digit BCD up/down counter with parallel load and validation,
// terminal count, and a per-digit 7-segment decoder with optional
// leading-zero blanking. Digit 0 is least significant.
module bcd_updown_counter_7seg #(
    parameter int unsigned DIGITS         = 2,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LZ       = 1'b0
) (
    input logic                      KEY_3,
    input logic                      SW17,
    bcd_updown_counter_7seg_if.slave bus
);
    localparam int unsigned BW = 4 * DIGITS;

    logic [BW-1:0]     bcd_q;
    logic [BW-1:0]     bcd_d;
    logic [BW-1:0]     inc_val;
    logic [BW-1:0]     dec_val;
    logic              load_err_q;
    logic              load_err_d;
    logic              load_ok;
    logic              all_nines;
    logic              all_zeros;
    logic              inc_carry;
    logic              dec_borrow;
    logic              lz_run;
    logic [DIGITS-1:0] blank;
    logic [6:0]        seg_lit;
    logic [6:0]        seg_digit;

    // Active-high pattern, bit 0 = segment a ... bit 6 = segment g.
    // Codes 10..15 cannot be held by the counter but decode to blank anyway.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Load value is accepted only if every digit is a legal BCD code.
    always_comb begin
        load_ok = 1'b1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (bus.load_val[4*k+:4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    // Wrap detection for the terminal-count output.
    always_comb begin
        all_nines = 1'b1;
        all_zeros = 1'b1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (bcd_q[4*k+:4] != 4'd9) begin
                all_nines = 1'b0;
            end
            if (bcd_q[4*k+:4] != 4'd0) begin
                all_zeros = 1'b0;
            end
        end
    end

    // Increment with carry rippling upward through digits sitting at 9.
    always_comb begin
        inc_carry = 1'b1;
        inc_val   = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (!inc_carry) begin
                inc_val[4*k+:4] = bcd_q[4*k+:4];
            end else if (bcd_q[4*k+:4] == 4'd9) begin
                inc_val[4*k+:4] = 4'd0;
            end else begin
                inc_val[4*k+:4] = bcd_q[4*k+:4] + 4'd1;
                inc_carry       = 1'b0;
            end
        end
    end

    // Decrement with borrow rippling upward through digits sitting at 0.
    always_comb begin
        dec_borrow = 1'b1;
        dec_val    = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (!dec_borrow) begin
                dec_val[4*k+:4] = bcd_q[4*k+:4];
            end else if (bcd_q[4*k+:4] == 4'd0) begin
                dec_val[4*k+:4] = 4'd9;
            end else begin
                dec_val[4*k+:4] = bcd_q[4*k+:4] - 4'd1;
                dec_borrow      = 1'b0;
            end
        end
    end

    // Next state: load beats count beats hold; a rejected load holds the count.
    always_comb begin
        bcd_d      = bcd_q;
        load_err_d = 1'b0;
        if (bus.load) begin
            if (load_ok) begin
                bcd_d = bus.load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.en) begin
            bcd_d = bus.up ? inc_val : dec_val;
        end
    end

    // Count and error-pulse registers, cleared asynchronously by SW17.
    always_ff @(posedge KEY_3 or posedge SW17) begin
        if (SW17) begin
            bcd_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            bcd_q      <= bcd_d;
            load_err_q <= load_err_d;
        end
    end

    // Leading-zero mask, scanned from the most significant digit down;
    // digit 0 is never blanked.
    always_comb begin
        blank  = '0;
        lz_run = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            lz_run   = lz_run & (bcd_q[4*k+:4] == 4'd0);
            blank[k] = BLANK_LZ & lz_run;
        end
    end

    // Per-digit segment drive with blanking and output polarity applied.
    always_comb begin
        bus.segments = '0;
        seg_lit      = '0;
        seg_digit    = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            seg_lit   = blank[k] ? 7'b0000000 : seg_decode(bcd_q[4*k+:4]);
            seg_digit = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
            bus.segments[7*k+:7] = seg_digit;
        end
    end

    // Status outputs; tc is forced low while reset is held.
    always_comb begin
        bus.bcd      = bcd_q;
        bus.load_err = load_err_q;
        bus.tc       = ~SW17 & bus.en & ~bus.load &
                       ((bus.up & all_nines) | (~bus.up & all_zeros));
    end
endmodule

// File: tb/tb_bcd_updown_counter_7seg.sv
// Directed bench for the BCD up/down counter: a 2-digit active-low instance
// without blanking and a 3-digit instance with leading-zero blanking.
module tb_bcd_updown_counter_7seg;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   tc_pulses;
    int   model;

    bcd_updown_counter_7seg_if #(.DIGITS(2)) bus2 ();
    bcd_updown_counter_7seg_if #(.DIGITS(3)) bus3 ();

    bcd_updown_counter_7seg #(
        .DIGITS(2),
        .SEG_ACTIVE_LOW(1'b1),
        .BLANK_LZ(1'b0)
    ) dut2 (
        .KEY_3(clk),
        .SW17(rst),
        .bus(bus2)
    );

    bcd_updown_counter_7seg #(
        .DIGITS(3),
        .SEG_ACTIVE_LOW(1'b1),
        .BLANK_LZ(1'b1)
    ) dut3 (
        .KEY_3(clk),
        .SW17(rst),
        .bus(bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low gfedcba constants used below.
    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_0     = 7'b1000000;
    localparam logic [6:0] S_1     = 7'b1111001;
    localparam logic [6:0] S_4     = 7'b0011001;
    localparam logic [6:0] S_5     = 7'b0010010;
    localparam logic [6:0] S_8     = 7'b0000000;
    localparam logic [6:0] S_9     = 7'b0010000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bcd2(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        tc_pulses = 0;
        rst       = 1'b1;
        bus2.en = 1'b0; bus2.up = 1'b0; bus2.load = 1'b0; bus2.load_val = '0;
        bus3.en = 1'b0; bus3.up = 1'b0; bus3.load = 1'b0; bus3.load_val = '0;

        #12;
        rst = 1'b0;
        check("por_bcd", 32'(bus2.bcd), 32'h00);
        check("por_err", 32'(bus2.load_err), 32'h0);

        // Load 47 so the asynchronous clear below is visible.
        bus2.load = 1'b1; bus2.load_val = 8'h47;
        step();
        bus2.load = 1'b0;
        check("pre_rst_bcd", 32'(bus2.bcd), 32'h47);

        // Assert reset mid-cycle: clears with no clock edge.
        #3;
        bus2.en = 1'b1; bus2.up = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_bcd", 32'(bus2.bcd), 32'h00);
        check("rst_seg", 32'(bus2.segments), 32'({S_0, S_0}));
        check("rst_tc", 32'(bus2.tc), 32'h0);
        check("rst_err", 32'(bus2.load_err), 32'h0);

        // A load pending on an edge while reset is held is discarded.
        bus2.load = 1'b1; bus2.load_val = 8'h33;
        step();
        check("rst_hold_bcd", 32'(bus2.bcd), 32'h00);
        rst = 1'b0;
        bus2.load = 1'b0;

        // Up count 00..99 and wrap; exactly one tc pulse at 99.
        bus2.en = 1'b1; bus2.up = 1'b1;
        for (int i = 0; i < 100; i++) begin
            check("up_bcd", 32'(bus2.bcd), 32'(bcd2(i)));
            check("up_tc", 32'(bus2.tc), (i == 99) ? 32'h1 : 32'h0);
            if (bus2.tc) tc_pulses++;
            step();
        end
        check("up_wrap", 32'(bus2.bcd), 32'h00);
        check("up_tc_pulses", 32'(tc_pulses), 32'd1);

        // Down count from 10 through 00 to 99 and 98.
        bus2.en = 1'b0; bus2.load = 1'b1; bus2.load_val = 8'h10;
        step();
        bus2.load = 1'b0; bus2.en = 1'b1; bus2.up = 1'b0;
        model = 10;
        for (int i = 0; i < 13; i++) begin
            check("dn_bcd", 32'(bus2.bcd), 32'(bcd2(model)));
            check("dn_tc", 32'(bus2.tc), (model == 0) ? 32'h1 : 32'h0);
            step();
            model = (model + 99) % 100;
        end
        check("dn_end", 32'(bus2.bcd), 32'h97);

        // Load wins over enable.
        bus2.load = 1'b1; bus2.load_val = 8'h47; bus2.en = 1'b1; bus2.up = 1'b1;
        step();
        check("ld_bcd", 32'(bus2.bcd), 32'h47);
        check("ld_err", 32'(bus2.load_err), 32'h0);

        // Invalid digit rejected; count holds and en is ignored.
        bus2.load_val = 8'h4A;
        check("ld_tc_masked", 32'(bus2.tc), 32'h0);
        step();
        check("bad_bcd", 32'(bus2.bcd), 32'h47);
        check("bad_err", 32'(bus2.load_err), 32'h1);
        bus2.load = 1'b0; bus2.en = 1'b0;
        step();
        check("bad_err_clr", 32'(bus2.load_err), 32'h0);
        check("bad_bcd2", 32'(bus2.bcd), 32'h47);

        // Hold for five edges.
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_bcd", 32'(bus2.bcd), 32'h47);
            check("hold_tc", 32'(bus2.tc), 32'h0);
        end
        bus2.en = 1'b1; bus2.up = 1'b1;
        step();
        bus2.en = 1'b0;
        check("inc_bcd", 32'(bus2.bcd), 32'h48);
        check("inc_seg", 32'(bus2.segments), 32'({S_4, S_8}));

        // Blanking on the 3-digit instance.
        check("lz_reset_seg", 32'(bus3.segments), 32'({S_BLANK, S_BLANK, S_0}));
        bus3.load = 1'b1; bus3.load_val = 12'h005;
        step();
        check("lz_005_bcd", 32'(bus3.bcd), 32'h005);
        check("lz_005_seg", 32'(bus3.segments), 32'({S_BLANK, S_BLANK, S_5}));
        bus3.load_val = 12'h100;
        step();
        check("lz_100_seg", 32'(bus3.segments), 32'({S_1, S_0, S_0}));
        bus3.load_val = 12'h050;
        step();
        check("lz_050_seg", 32'(bus3.segments), 32'({S_BLANK, S_5, S_0}));
        bus3.load_val = 12'h000;
        step();
        check("lz_000_seg", 32'(bus3.segments), 32'({S_BLANK, S_BLANK, S_0}));

        // Invalid high digit rejected on the 3-digit instance.
        bus3.load_val = 12'hB00;
        step();
        check("lz_bad_bcd", 32'(bus3.bcd), 32'h000);
        check("lz_bad_err", 32'(bus3.load_err), 32'h1);

        // 999 wraps to 000 with tc high beforehand.
        bus3.load_val = 12'h999;
        step();
        bus3.load = 1'b0; bus3.en = 1'b1; bus3.up = 1'b1;
        #1;
        check("w999_seg", 32'(bus3.segments), 32'({S_9, S_9, S_9}));
        check("w999_tc", 32'(bus3.tc), 32'h1);
        step();
        check("w999_wrap", 32'(bus3.bcd), 32'h000);
        check("w999_tc_low", 32'(bus3.tc), 32'h0);
        bus3.up = 1'b0;
        #1;
        check("w000_tc", 32'(bus3.tc), 32'h1);
        step();
        check("w000_wrap", 32'(bus3.bcd), 32'h999);
        bus3.en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
